// File: rtl/qspi_flash_op_sequencer.sv
// QSPI flash modify-operation sequencer:
// WREN, WEL check, program/erase, then WIP polling.
module qspi_flash_op_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 9,
  parameter int POLL_GAP  = 64,
  parameter int MAX_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        op_opcode,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [LEN_W-1:0]  op_len,
  output logic              busy,
  output logic              done,
  output logic              err_wel,
  output logic              err_timeout,
  output logic [7:0]        status_last,
  output logic              eng_req,
  input  logic              eng_ack,
  output logic [7:0]        eng_opcode,
  output logic [ADDR_W-1:0] eng_addr,
  output logic              eng_addr_en,
  output logic [LEN_W-1:0]  eng_len,
  output logic              eng_rd,
  input  logic              eng_done,
  input  logic [7:0]        eng_rdata
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);
  localparam logic [GW-1:0] GAP_LD   = GW'(POLL_GAP);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WREN_REQ  = 4'd1;
  localparam logic [3:0] S_WREN_WAIT = 4'd2;
  localparam logic [3:0] S_WEL_REQ   = 4'd3;
  localparam logic [3:0] S_WEL_WAIT  = 4'd4;
  localparam logic [3:0] S_OP_REQ    = 4'd5;
  localparam logic [3:0] S_OP_WAIT   = 4'd6;
  localparam logic [3:0] S_GAP       = 4'd7;
  localparam logic [3:0] S_POLL_REQ  = 4'd8;
  localparam logic [3:0] S_POLL_WAIT = 4'd9;
  localparam logic [3:0] S_FIN       = 4'd10;

  logic [3:0]        state;
  logic [7:0]        opc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [PW-1:0]     poll_cnt;
  logic [PW-1:0]     poll_nxt;
  logic [GW-1:0]     gap_cnt;

  assign poll_nxt = (poll_cnt == POLL_MAX) ?
                    poll_cnt : poll_cnt + PW'(1);

  // Fields are held through the WAIT state as well as the REQ state
  always_comb begin
    eng_req     = 1'b0;
    eng_opcode  = 8'h00;
    eng_addr    = '0;
    eng_addr_en = 1'b0;
    eng_len     = '0;
    eng_rd      = 1'b0;
    case (state)
      S_WREN_REQ, S_WREN_WAIT: begin
        eng_opcode = 8'h06;
      end
      S_WEL_REQ, S_WEL_WAIT,
      S_POLL_REQ, S_POLL_WAIT: begin
        eng_opcode = 8'h05;
        eng_len    = LEN_W'(1);
        eng_rd     = 1'b1;
      end
      S_OP_REQ, S_OP_WAIT: begin
        eng_opcode  = opc_q;
        eng_addr    = addr_q;
        eng_addr_en = 1'b1;
        eng_len     = len_q;
      end
      default: ;
    endcase
    eng_req = (state == S_WREN_REQ) ||
              (state == S_WEL_REQ)  ||
              (state == S_OP_REQ)   ||
              (state == S_POLL_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_wel     <= 1'b0;
      err_timeout <= 1'b0;
      status_last <= 8'h00;
      opc_q       <= 8'h00;
      addr_q      <= '0;
      len_q       <= '0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          opc_q       <= op_opcode;
          addr_q      <= op_addr;
          len_q       <= op_len;
          err_wel     <= 1'b0;
          err_timeout <= 1'b0;
          poll_cnt    <= '0;
          busy        <= 1'b1;
          state       <= S_WREN_REQ;
        end
        S_WREN_REQ:
          if (eng_ack) state <= S_WREN_WAIT;
        S_WREN_WAIT:
          if (eng_done) state <= S_WEL_REQ;
        S_WEL_REQ:
          if (eng_ack) state <= S_WEL_WAIT;
        S_WEL_WAIT: if (eng_done) begin
          status_last <= eng_rdata;
          if (eng_rdata[1]) begin
            state <= S_OP_REQ;
          end else begin
            err_wel <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_OP_REQ:
          if (eng_ack) state <= S_OP_WAIT;
        S_OP_WAIT: if (eng_done) begin
          gap_cnt <= GAP_LD;
          state   <= S_GAP;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state <= S_POLL_REQ;
        end
        S_POLL_REQ:
          if (eng_ack) state <= S_POLL_WAIT;
        S_POLL_WAIT: if (eng_done) begin
          status_last <= eng_rdata;
          poll_cnt    <= poll_nxt;
          if (!eng_rdata[0]) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else if (poll_nxt == POLL_MAX) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_FIN;
          end else begin
            gap_cnt <= GAP_LD;
            state   <= S_GAP;
          end
        end
        S_FIN:
          state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_op_sequencer.sv
// Scoreboard bench for qspi_flash_op_sequencer with
// a reactive engine model and a high-level reference.
module tb_qspi_flash_op_sequencer;

  localparam int AW = 32;
  localparam int LW = 9;
  localparam int PG = 8;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    op_opcode;
  logic [AW-1:0] op_addr;
  logic [LW-1:0] op_len;
  logic          busy, done, err_wel, err_timeout;
  logic [7:0]    status_last;
  logic          eng_req, eng_ack;
  logic [7:0]    eng_opcode;
  logic [AW-1:0] eng_addr;
  logic          eng_addr_en;
  logic [LW-1:0] eng_len;
  logic          eng_rd, eng_done;
  logic [7:0]    eng_rdata;

  always #5 clk = ~clk;

  qspi_flash_op_sequencer #(
    .ADDR_W(AW), .LEN_W(LW),
    .POLL_GAP(PG), .MAX_POLLS(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_opcode(op_opcode), .op_addr(op_addr),
    .op_len(op_len), .busy(busy), .done(done),
    .err_wel(err_wel), .err_timeout(err_timeout),
    .status_last(status_last), .eng_req(eng_req),
    .eng_ack(eng_ack), .eng_opcode(eng_opcode),
    .eng_addr(eng_addr), .eng_addr_en(eng_addr_en),
    .eng_len(eng_len), .eng_rd(eng_rd),
    .eng_done(eng_done), .eng_rdata(eng_rdata)
  );

  typedef struct packed {
    logic [7:0]    opc;
    logic          aen;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          rd;
    logic          gap;
  } txn_t;

  typedef struct packed {
    logic       wel;
    logic       to;
    logic [7:0] st;
  } res_t;

  txn_t       exp_q[$];
  res_t       res_q[$];
  logic [7:0] scr_q[$];
  logic [7:0] sc[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int edone_cnt = 0;
  int rise_cyc = 0;
  int edone_cyc = 0;
  int ack_lo = 0, ack_hi = 0;
  int dn_lo = 0, dn_hi = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  function automatic txn_t mk(
    input logic [7:0] o, input logic a,
    input logic [AW-1:0] ad, input logic [LW-1:0] l,
    input logic r, input logic g);
    txn_t t;
    t.opc = o; t.aen = a; t.addr = ad;
    t.len = l; t.rd = r; t.gap = g;
    return t;
  endfunction

  // Reference: the status bytes decide the whole transaction list
  task automatic expect_op(input logic [7:0] o,
                           input logic [AW-1:0] a,
                           input logic [LW-1:0] l,
                           input logic [7:0] s[$]);
    res_t r;
    r = '0;
    exp_q.push_back(mk(8'h06, 1'b0, '0, '0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h05, 1'b0, '0, 1, 1'b1, 1'b0));
    if (!s[0][1]) begin
      r = '{1'b1, 1'b0, s[0]};
    end else begin
      exp_q.push_back(mk(o, 1'b1, a, l, 1'b0, 1'b0));
      for (int i = 1; i <= MP; i++) begin
        exp_q.push_back(mk(8'h05, 1'b0, '0, 1, 1'b1, 1'b1));
        if (!s[i][0]) begin
          r = '{1'b0, 1'b0, s[i]};
          break;
        end
        if (i == MP) r = '{1'b0, 1'b1, s[i]};
      end
    end
    res_q.push_back(r);
  endtask

  task automatic launch(input logic [7:0] o,
                        input logic [AW-1:0] a,
                        input logic [LW-1:0] l,
                        input logic [7:0] s[$]);
    expect_op(o, a, l, s);
    scr_q = s;
    @(negedge clk);
    op_opcode = o; op_addr = a; op_len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_opcode = 8'($urandom);
    op_addr = AW'($urandom);
    op_len = LW'($urandom);
  endtask

  task automatic wait_done(input bit extra, input bit fin_st);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done_cnt != d0) break;
      if (fin_st && done) start = 1'b1;
      if (extra && (n % 7 == 3)) begin
        start = 1'b1;
        op_opcode = 8'h02;
      end
    end
    start = 1'b0;
    if (done_cnt == d0) fail("done_timeout");
  endtask

  task automatic rand_script();
    int nb;
    sc = {};
    if ($urandom_range(4, 0) == 0)
      sc.push_back(8'($urandom) & 8'hFD);
    else
      sc.push_back(8'($urandom) | 8'h02);
    nb = $urandom_range(5, 0);
    for (int i = 0; i < nb; i++)
      sc.push_back(8'($urandom) | 8'h01);
    for (int i = 0; i < MP; i++)
      sc.push_back(8'($urandom) & 8'hFE);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_wel", err_wel, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_status", status_last, 0);
    chk("rst_req", eng_req, 0);
    chk("rst_aen", eng_addr_en, 0);
    chk("rst_rd", eng_rd, 0);
    chk("rst_opc", eng_opcode, 0);
    chk("rst_addr", eng_addr, 0);
    chk("rst_len", eng_len, 0);
  endtask

  // Engine model: ack after a delay, then a done pulse
  initial begin
    logic rd_now;
    eng_ack = 1'b0;
    eng_done = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      eng_ack = 1'b0;
      eng_done = 1'b0;
      if (rst_n === 1'b1 && eng_req === 1'b1) begin
        rd_now = eng_rd;
        repeat ($urandom_range(ack_hi, ack_lo)) @(negedge clk);
        eng_ack = 1'b1;
        @(negedge clk);
        eng_ack = 1'b0;
        repeat ($urandom_range(dn_hi, dn_lo)) @(negedge clk);
        eng_done = 1'b1;
        if (rd_now && scr_q.size() > 0)
          eng_rdata = scr_q.pop_front();
        else
          eng_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations on handshakes and done pulses
  initial begin
    logic        prev_req;
    logic [50:0] prev_f;
    logic [50:0] cur_f;
    txn_t        t;
    res_t        r;
    prev_req = 1'b0;
    prev_f = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      cur_f = {eng_opcode, eng_addr, eng_len,
               eng_rd, eng_addr_en};
      if (rst_n !== 1'b1) begin
        prev_req = 1'b0;
      end else begin
        if (eng_req && !prev_req) rise_cyc = cyc;
        if (eng_req && prev_req)
          chk("eng_stable", cur_f, prev_f);
        prev_req = eng_req;
        prev_f = cur_f;
        if (eng_req && eng_ack) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_req");
          end else begin
            t = exp_q.pop_front();
            chk("eng_opcode", eng_opcode, t.opc);
            chk("eng_addr_en", eng_addr_en, t.aen);
            if (t.aen) chk("eng_addr", eng_addr, t.addr);
            chk("eng_len", eng_len, t.len);
            chk("eng_rd", eng_rd, t.rd);
            chk("busy_in_op", busy, 1);
            if (t.gap)
              chk("poll_gap", rise_cyc - edone_cyc, PG + 1);
          end
        end
        if (eng_done) begin
          edone_cyc = cyc;
          edone_cnt++;
        end
        if (done) begin
          done_cnt++;
          if (res_q.size() == 0) begin
            fail("unexpected_done");
          end else begin
            r = res_q.pop_front();
            chk("err_wel", err_wel, r.wel);
            chk("err_timeout", err_timeout, r.to);
            chk("status_last", status_last, r.st);
            chk("busy_at_done", busy, 0);
          end
        end
      end
    end
  end

  initial begin
    int e0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    op_opcode = '0;
    op_addr = '0;
    op_len = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    ack_lo = 1; ack_hi = 1; dn_lo = 20; dn_hi = 20;
    sc = {8'h02, 8'h03, 8'h03, 8'h00};
    launch(8'h02, 32'h100, 9'd4, sc);
    wait_done(1'b0, 1'b0);

    ack_lo = 0; ack_hi = 3; dn_lo = 0; dn_hi = 3;
    sc = {8'h02, 8'h00};
    launch(8'h20, 32'h1000, 9'd0, sc);
    wait_done(1'b0, 1'b0);

    sc = {8'h00};
    launch(8'h02, 32'h2000, 9'd16, sc);
    wait_done(1'b0, 1'b0);

    sc = {8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
    launch(8'hD8, 32'h10000, 9'd0, sc);
    wait_done(1'b0, 1'b0);

    ack_lo = 5; ack_hi = 5;
    sc = {8'h02, 8'h01, 8'h00};
    launch(8'h02, 32'hABCD00, 9'd256, sc);
    wait_done(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    chk("fin_start_busy", busy, 0);
    chk("fin_start_req", eng_req, 0);
    chk("fin_start_q", exp_q.size(), 0);

    ack_lo = 0; ack_hi = 2; dn_lo = 0; dn_hi = 2;
    sc = {8'h02, 8'h03, 8'h03, 8'h03, 8'h00};
    e0 = edone_cnt;
    launch(8'h02, 32'h300, 9'd8, sc);
    n = 0;
    while (edone_cnt < e0 + 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (edone_cnt < e0 + 4) fail("gap_wait_timeout");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q = {};
    res_q = {};
    scr_q = {};
    @(negedge clk);
    rst_n = 1'b1;
    sc = {8'h02, 8'h01, 8'h01, 8'h01, 8'h00};
    launch(8'h02, 32'h400, 9'd2, sc);
    wait_done(1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      ack_hi = $urandom_range(4, 0);
      dn_hi = $urandom_range(6, 0);
      rand_script();
      launch(8'($urandom), AW'($urandom),
             LW'($urandom_range(256, 0)), sc);
      wait_done(k[0], 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("txn_q_empty", exp_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qspi_flash_op_sequencer.md
Name: qspi_flash_op_sequencer

Overview:
Hardware sequencer that runs a complete flash modify operation (program or erase) through the QSPI controller's command engine without CPU intervention. It issues WREN (0x06), checks WEL by reading the status register (0x05), issues the program or erase command, then polls the status register until WIP clears or a poll limit expires. It sits between the APB register block, which supplies start, opcode, address and length, and the command-mode engine, which owns the QSPI pins. The DMA and FIFO data paths are untouched.

Parameters:
ADDR_W, 32, flash address width
LEN_W, 9, data-phase byte count width (max 256-byte page)
POLL_GAP, 64, idle clk cycles between status polls (>=1)
MAX_POLLS, 1024, status reads before timeout (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one operation
op_opcode  in  8  program/erase opcode (e.g. 0x02, 0x20, 0xD8)
op_addr  in  ADDR_W  flash address for op_opcode
op_len  in  LEN_W  data bytes for op_opcode; 0 = no data phase (erase)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at operation end (success or error)
err_wel  out  1  sticky: WEL not set after WREN
err_timeout  out  1  sticky: WIP still set after MAX_POLLS reads
status_last  out  8  last status byte read
eng_req  out  1  command request to engine
eng_ack  in  1  engine accepts request (handshake when eng_req&eng_ack)
eng_opcode  out  8  instruction byte
eng_addr  out  ADDR_W  address for the address phase
eng_addr_en  out  1  address phase present
eng_len  out  LEN_W  data-phase byte count
eng_rd  out  1  data phase direction, 1=read from flash
eng_done  in  1  one-cycle pulse, engine transaction complete
eng_rdata  in  8  first read byte, valid with eng_done

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, err_wel, err_timeout, eng_req, eng_addr_en and eng_rd are 0. status_last, eng_opcode, eng_addr and eng_len are 0. The poll and gap counters clear. Reset mid-operation abandons the sequence immediately. Any in-flight engine transaction is the engine's concern.
- States: IDLE, WREN_REQ, WREN_WAIT, WEL_REQ, WEL_WAIT, OP_REQ, OP_WAIT, GAP, POLL_REQ, POLL_WAIT, FIN.
- IDLE: start=1 latches op_opcode, op_addr and op_len, clears err_wel, err_timeout and poll_cnt, sets busy. Next state WREN_REQ, so eng_req rises the cycle after start. start is ignored in every other state.
- *_REQ states: eng_req=1 with stable eng_* fields until the cycle eng_req&eng_ack. eng_req then drops and the block moves to the matching *_WAIT state. eng_done is ignored outside *_WAIT states.
- Per-state engine fields:
  - WREN: opcode 0x06, addr_en 0, len 0, rd 0.
  - WEL and POLL: opcode 0x05, addr_en 0, len 1, rd 1.
  - OP: latched opcode, addr_en 1, eng_addr = latched addr, len = latched len, rd 0.
- WREN_WAIT: on eng_done, go to WEL_REQ.
- WEL_WAIT: on eng_done, status_last <= eng_rdata. If bit1=1, go to OP_REQ. Otherwise set err_wel and go to FIN; the program/erase is not issued.
- OP_WAIT: on eng_done, load the gap counter with POLL_GAP and go to GAP.
- GAP: decrement the counter each cycle; at 1, go to POLL_REQ. The gap is exactly POLL_GAP cycles.
- POLL_WAIT: on eng_done, status_last <= eng_rdata and poll_cnt++.
  - bit0=0: go to FIN.
  - Otherwise, if poll_cnt (after increment) == MAX_POLLS: set err_timeout and go to FIN.
  - Otherwise: go to GAP.
- poll_cnt width is clog2(MAX_POLLS+1) and it never wraps.
- FIN: done=1 for one cycle, busy=0 in the same cycle (both registered), then IDLE. A start in the FIN cycle is ignored. A start in the following cycle is accepted.
- Error flags hold until the next accepted start or reset.

Test Plan:
- Program 0x02, addr 0x000100, len 4. Engine acks after 1 cycle, done after 20. RDSR returns 0x02 (WEL), then 0x03, 0x03, 0x00 -> engine opcodes 06,05,02,05,05,05. The OP request carries addr 0x100 and len 4. Exactly POLL_GAP idle cycles separate the polls. done pulses once; status_last=0x00, errors 0.
- Sector erase 0x20, addr 0x001000, len 0 -> OP request has eng_len=0, eng_rd=0, eng_addr_en=1. Completes after the first poll returns 0x00.
- WEL fail: status after WREN returns 0x00 -> err_wel=1, done pulse, no 0x02 request ever raised, busy falls with done.
- Timeout with MAX_POLLS=4: RDSR always returns 0x03 -> exactly 4 polls, err_timeout=1, status_last=0x03, one done pulse.
- eng_ack delayed 5 cycles, plus extra start pulses while busy -> eng_* fields stable while eng_req is high, starts ignored, single sequence executed.
- rst_n asserted during GAP -> all outputs at reset values immediately. A fresh start afterwards runs a clean full sequence with poll_cnt restarted from 0.
